// File: rtl/julia_pkg.sv
// Shared types and helpers for the Julia frame engine.
// Optional feature macro used by the engine: JULIA_MANDEL_EN (adds mandel_mode input).
package julia_pkg;

  // Default fixed-point format; the engine and core are parameterised and
  // derive their own widths, these document the standard build.
  localparam int DEF_DATA_W    = 22;
  localparam int DEF_FRAC_BITS = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ITER  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef logic signed [DEF_DATA_W-1:0] fixed_t;

  // |z|^2 escape threshold (4.0) in the squared-product scale of the default format.
  localparam logic [2*DEF_DATA_W:0] ESCAPE_R2 =
    {{(2*DEF_DATA_W-2-2*DEF_FRAC_BITS){1'b0}}, 3'b100, {(2*DEF_FRAC_BITS){1'b0}}};

  // Byte address of a pixel: one 32-bit word per pixel.
  function automatic logic [31:0] pixel_to_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + {idx[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/julia_iter_core.sv
// One Julia/Mandelbrot step: z^2 + c and the escape test on the current z.
// Purely combinational; every product is shifted back by FRAC_BITS and
// truncated to DATA_W before it is combined, so results wrap mod 2^DATA_W.
module julia_iter_core #(
  parameter int DATA_W    = 22,
  parameter int FRAC_BITS = 10
) (
  input  logic signed [DATA_W-1:0] zr,
  input  logic signed [DATA_W-1:0] zi,
  input  logic signed [DATA_W-1:0] cr,
  input  logic signed [DATA_W-1:0] ci,
  output logic signed [DATA_W-1:0] nzr,
  output logic signed [DATA_W-1:0] nzi,
  output logic                     escape
);

  // 4.0 expressed in the scale of a full-precision square (2*FRAC_BITS fraction bits).
  localparam logic signed [2*DATA_W:0] ESC_R2 =
    {{(2*DATA_W-2-2*FRAC_BITS){1'b0}}, 3'b100, {(2*FRAC_BITS){1'b0}}};

  logic signed [2*DATA_W-1:0] zr_x_s;
  logic signed [2*DATA_W-1:0] zi_x_s;
  logic signed [2*DATA_W-1:0] zr2_s;
  logic signed [2*DATA_W-1:0] zi2_s;
  logic signed [2*DATA_W-1:0] zrzi_s;
  logic signed [2*DATA_W:0]   mag2_s;
  logic signed [2*DATA_W-1:0] zr2_sh_s;
  logic signed [2*DATA_W-1:0] zi2_sh_s;
  logic signed [2*DATA_W-1:0] zrzi_sh_s;
  logic signed [DATA_W-1:0]   zr2_t_s;
  logic signed [DATA_W-1:0]   zi2_t_s;
  logic signed [DATA_W-1:0]   zrzi_t_s;

  // Full-precision squares for the escape test, rescaled products for the update.
  always_comb begin
    zr_x_s    = {{DATA_W{zr[DATA_W-1]}}, zr};
    zi_x_s    = {{DATA_W{zi[DATA_W-1]}}, zi};
    zr2_s     = zr_x_s * zr_x_s;
    zi2_s     = zi_x_s * zi_x_s;
    zrzi_s    = zr_x_s * zi_x_s;
    mag2_s    = {zr2_s[2*DATA_W-1], zr2_s} + {zi2_s[2*DATA_W-1], zi2_s};
    escape    = (mag2_s > ESC_R2);
    zr2_sh_s  = zr2_s >>> FRAC_BITS;
    zi2_sh_s  = zi2_s >>> FRAC_BITS;
    zrzi_sh_s = zrzi_s >>> FRAC_BITS;
    zr2_t_s   = zr2_sh_s[DATA_W-1:0];
    zi2_t_s   = zi2_sh_s[DATA_W-1:0];
    zrzi_t_s  = zrzi_sh_s[DATA_W-1:0];
    nzr       = zr2_t_s - zi2_t_s + cr;
    nzi       = {zrzi_t_s[DATA_W-2:0], 1'b0} + ci;
  end

endmodule

// File: rtl/julia_frame_engine.sv
// Julia-set frame generator: scans IMG_W x IMG_H pixels in row-major order,
// iterates z = z^2 + c per pixel and writes the escape count to frame memory
// through a wr_ready/wr_done handshake.
// Optional macro JULIA_MANDEL_EN adds a mandel_mode input (c = pixel, z0 = 0).
module julia_frame_engine
  import julia_pkg::*;
#(
  parameter int          DATA_W    = 22,
  parameter int          FRAC_BITS = 10,
  parameter int          IMG_W     = 640,
  parameter int          IMG_H     = 480,
  parameter int          ITER_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_sig,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] x_min,
  input  logic [DATA_W-1:0] y_min,
  input  logic [DATA_W-1:0] step,
  input  logic [ITER_W-1:0] max_iter,
`ifdef JULIA_MANDEL_EN
  input  logic              mandel_mode,
`endif
  input  logic              wr_done,
  output logic              wr_ready,
  output logic [31:0]       wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              frame_done
);

  localparam int          COL_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int          ROW_W    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [31:0] LAST_IDX = 32'(IMG_W * IMG_H - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);

  state_t              state_r;
  logic [COL_W-1:0]    col_r;
  logic [ROW_W-1:0]    row_r;
  logic [31:0]         idx_r;
  logic [DATA_W-1:0]   a_r;
  logic [DATA_W-1:0]   b_r;
  logic [DATA_W-1:0]   xmin_r;
  logic [DATA_W-1:0]   ymin_r;
  logic [DATA_W-1:0]   step_r;
  logic [ITER_W-1:0]   max_r;
  logic [ITER_W-1:0]   iter_r;
  logic [DATA_W-1:0]   zr_r;
  logic [DATA_W-1:0]   zi_r;
  logic [DATA_W-1:0]   cr_r;
  logic [DATA_W-1:0]   ci_r;
  logic                wr_ready_r;
  logic [31:0]         wr_addr_r;
  logic [31:0]         wr_data_r;
  logic                busy_r;
  logic                frame_done_r;
`ifdef JULIA_MANDEL_EN
  logic                mandel_r;
`endif

  logic [DATA_W-1:0]   col_fx_s;
  logic [DATA_W-1:0]   row_fx_s;
  logic [DATA_W-1:0]   px_re_s;
  logic [DATA_W-1:0]   px_im_s;
  logic [DATA_W-1:0]   nzr_s;
  logic [DATA_W-1:0]   nzi_s;
  logic                esc_s;

  // Complex coordinate of the current pixel; products wrap mod 2^DATA_W.
  always_comb begin
    col_fx_s = DATA_W'(col_r);
    row_fx_s = DATA_W'(row_r);
    px_re_s  = xmin_r + col_fx_s * step_r;
    px_im_s  = ymin_r + row_fx_s * step_r;
  end

  julia_iter_core #(
    .DATA_W    (DATA_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_core (
    .zr     (zr_r),
    .zi     (zi_r),
    .cr     (cr_r),
    .ci     (ci_r),
    .nzr    (nzr_s),
    .nzi    (nzi_s),
    .escape (esc_s)
  );

  // Frame FSM: parameter capture, pixel scan, iteration and write handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      col_r        <= '0;
      row_r        <= '0;
      idx_r        <= 32'd0;
      a_r          <= '0;
      b_r          <= '0;
      xmin_r       <= '0;
      ymin_r       <= '0;
      step_r       <= '0;
      max_r        <= '0;
      iter_r       <= '0;
      zr_r         <= '0;
      zi_r         <= '0;
      cr_r         <= '0;
      ci_r         <= '0;
      wr_ready_r   <= 1'b0;
      wr_addr_r    <= 32'd0;
      wr_data_r    <= 32'd0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
`ifdef JULIA_MANDEL_EN
      mandel_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start_sig) begin
            a_r      <= a;
            b_r      <= b;
            xmin_r   <= x_min;
            ymin_r   <= y_min;
            step_r   <= step;
            max_r    <= max_iter;
`ifdef JULIA_MANDEL_EN
            mandel_r <= mandel_mode;
`endif
            col_r    <= '0;
            row_r    <= '0;
            idx_r    <= 32'd0;
            busy_r   <= 1'b1;
            state_r  <= LOAD;
          end else begin
            state_r  <= IDLE;
          end
        end
        LOAD: begin
`ifdef JULIA_MANDEL_EN
          if (mandel_r) begin
            zr_r <= '0;
            zi_r <= '0;
            cr_r <= px_re_s;
            ci_r <= px_im_s;
          end else
`endif
          begin
            zr_r <= px_re_s;
            zi_r <= px_im_s;
            cr_r <= a_r;
            ci_r <= b_r;
          end
          iter_r  <= '0;
          state_r <= ITER;
        end
        ITER: begin
          // The count written is the number of updates already applied.
          if (esc_s || (iter_r == max_r)) begin
            wr_ready_r <= 1'b1;
            wr_addr_r  <= pixel_to_addr(BASE_ADDR, idx_r);
            wr_data_r  <= 32'(iter_r);
            state_r    <= WRITE;
          end else begin
            zr_r   <= nzr_s;
            zi_r   <= nzi_s;
            iter_r <= iter_r + ITER_W'(1);
          end
        end
        WRITE: begin
          if (wr_done) begin
            wr_ready_r <= 1'b0;
            if (idx_r == LAST_IDX) begin
              frame_done_r <= 1'b1;
              state_r      <= DONE;
            end else begin
              idx_r <= idx_r + 32'd1;
              if (col_r == LAST_COL) begin
                col_r <= '0;
                row_r <= row_r + ROW_W'(1);
              end else begin
                col_r <= col_r + COL_W'(1);
              end
              state_r <= LOAD;
            end
          end else begin
            state_r <= WRITE;
          end
        end
        DONE: begin
          frame_done_r <= 1'b0;
          busy_r       <= 1'b0;
          state_r      <= IDLE;
        end
        default: begin
          wr_ready_r   <= 1'b0;
          busy_r       <= 1'b0;
          frame_done_r <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign wr_ready   = wr_ready_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_julia_frame_engine.sv
// Self-checking bench for julia_frame_engine: a 4x2 instance (base 0x1000)
// and a 1x1 instance (base 0), checked against an arithmetic escape-count model.
module tb_julia_frame_engine;

  localparam int     DW  = 22;
  localparam int     IW  = 8;
  localparam longint ESC = 64'sd4 <<< 20;

  logic tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  logic rst;

  logic          start_a, wr_done_a, wr_ready_a, busy_a, frame_done_a;
  logic [DW-1:0] a_a, b_a, xmin_a, ymin_a, step_a;
  logic [IW-1:0] maxit_a;
  logic [31:0]   wr_addr_a, wr_data_a;

  logic          start_b, wr_done_b, wr_ready_b, busy_b, frame_done_b;
  logic [DW-1:0] a_b, b_b, xmin_b, ymin_b, step_b;
  logic [IW-1:0] maxit_b;
  logic [31:0]   wr_addr_b, wr_data_b;
`ifdef JULIA_MANDEL_EN
  logic          mandel_a, mandel_b;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt [8];

  julia_frame_engine #(.IMG_W(4), .IMG_H(2), .BASE_ADDR(32'h1000)) dut_a (
    .clk(tb_clk), .rst(rst), .start_sig(start_a), .a(a_a), .b(b_a),
    .x_min(xmin_a), .y_min(ymin_a), .step(step_a), .max_iter(maxit_a),
`ifdef JULIA_MANDEL_EN
    .mandel_mode(mandel_a),
`endif
    .wr_done(wr_done_a), .wr_ready(wr_ready_a), .wr_addr(wr_addr_a),
    .wr_data(wr_data_a), .busy(busy_a), .frame_done(frame_done_a)
  );

  julia_frame_engine #(.IMG_W(1), .IMG_H(1), .BASE_ADDR(32'h0)) dut_b (
    .clk(tb_clk), .rst(rst), .start_sig(start_b), .a(a_b), .b(b_b),
    .x_min(xmin_b), .y_min(ymin_b), .step(step_b), .max_iter(maxit_b),
`ifdef JULIA_MANDEL_EN
    .mandel_mode(mandel_b),
`endif
    .wr_done(wr_done_b), .wr_ready(wr_ready_b), .wr_addr(wr_addr_b),
    .wr_data(wr_data_b), .busy(busy_b), .frame_done(frame_done_b)
  );

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  // Interpret the low 22 bits as a signed fixed-point word.
  function automatic longint wrap_fx(input longint v);
    longint m;
    m = v & 64'sh3F_FFFF;
    if (m >= 64'sh20_0000) m = m - 64'sh40_0000;
    return m;
  endfunction

  // Escape count of one orbit: iterations done before |z|^2 exceeds 4, capped at mx.
  function automatic int model_count(input longint zr0, input longint zi0,
                                     input longint cr, input longint ci, input int mx);
    longint zr, zi, t;
    zr = zr0;
    zi = zi0;
    for (int n = 0; n < mx; n++) begin
      if (zr * zr + zi * zi > ESC) return n;
      t  = wrap_fx(wrap_fx((zr * zr) >>> 10) - wrap_fx((zi * zi) >>> 10) + cr);
      zi = wrap_fx(2 * wrap_fx((zr * zi) >>> 10) + ci);
      zr = t;
    end
    return mx;
  endfunction

  task automatic set_frame_a(input longint av, input longint bv, input longint xm,
                             input longint ym, input longint st, input int mx);
    a_a     = 22'(av);
    b_a     = 22'(bv);
    xmin_a  = 22'(xm);
    ymin_a  = 22'(ym);
    step_a  = 22'(st);
    maxit_a = 8'(mx);
    for (int p = 0; p < 8; p++)
      exp_cnt[p] = model_count(wrap_fx(xm + (p % 4) * st), wrap_fx(ym + (p / 4) * st), av, bv, mx);
  endtask

  // Runs one frame on dut_a, checking every write; optionally stalls one pixel,
  // pulses start mid-frame, or aborts with reset while pixel abort_pix is pending.
  task automatic run_frame_a(input int stall_pix, input int stall_len, input bit rand_wait,
                             input bit mid_start, input int abort_pix);
    int waited, hold;
    logic [31:0] hold_addr, hold_data;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n_cmp++;
    if (busy_a !== 1'b1) begin
      n_err++;
      $display("FAIL busy_after_start: got %b want 1", busy_a);
    end
    for (int p = 0; p < 8; p++) begin
      waited = 0;
      while (wr_ready_a !== 1'b1 && waited < 400) begin
        if (mid_start && p == 4 && waited == 0) start_a = 1'b1;
        tick();
        start_a = 1'b0;
        waited++;
        n_cmp++;
        if (frame_done_a !== 1'b0) begin
          n_err++;
          $display("FAIL early_frame_done: pixel %0d got %b want 0", p, frame_done_a);
        end
      end
      n_cmp++;
      if (waited >= 400) begin
        n_err++;
        $display("FAIL write_timeout: pixel %0d got no wr_ready want wr_ready within 400 cycles", p);
        return;
      end
      n_cmp++;
      if (wr_addr_a !== 32'h1000 + 32'(4 * p)) begin
        n_err++;
        $display("FAIL wr_addr: pixel %0d got %h want %h", p, wr_addr_a, 32'h1000 + 32'(4 * p));
      end
      n_cmp++;
      if (wr_data_a !== 32'(exp_cnt[p])) begin
        n_err++;
        $display("FAIL wr_data: pixel %0d got %0d want %0d", p, wr_data_a, exp_cnt[p]);
      end
      if (p == abort_pix) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (wr_ready_a !== 1'b0 || busy_a !== 1'b0 || frame_done_a !== 1'b0) begin
          n_err++;
          $display("FAIL abort_reset: got ready=%b busy=%b done=%b want 0 0 0",
                   wr_ready_a, busy_a, frame_done_a);
        end
        return;
      end
      hold = rand_wait ? int'($urandom_range(0, 3)) : ((p == stall_pix) ? stall_len : 0);
      hold_addr = wr_addr_a;
      hold_data = wr_data_a;
      for (int h = 0; h < hold; h++) begin
        tick();
        n_cmp++;
        if (wr_ready_a !== 1'b1 || wr_addr_a !== hold_addr || wr_data_a !== hold_data) begin
          n_err++;
          $display("FAIL stall_stable: pixel %0d got ready=%b addr=%h data=%0d want 1 %h %0d",
                   p, wr_ready_a, wr_addr_a, wr_data_a, hold_addr, hold_data);
        end
      end
      wr_done_a = 1'b1;
      tick();
      wr_done_a = 1'b0;
      n_cmp++;
      if (wr_ready_a !== 1'b0) begin
        n_err++;
        $display("FAIL ready_drop: pixel %0d got %b want 0", p, wr_ready_a);
      end
      n_cmp++;
      if (frame_done_a !== (p == 7)) begin
        n_err++;
        $display("FAIL frame_done_pulse: pixel %0d got %b want %b", p, frame_done_a, p == 7);
      end
    end
    tick();
    n_cmp++;
    if (frame_done_a !== 1'b0 || busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL frame_end: got done=%b busy=%b want 0 0", frame_done_a, busy_a);
    end
  endtask

  // Single-pixel frame on dut_b; checks the one write and the done pulse.
  task automatic run_single_b(input int want);
    int waited;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    waited = 0;
    while (wr_ready_b !== 1'b1 && waited < 400) begin
      tick();
      waited++;
    end
    n_cmp++;
    if (wr_ready_b !== 1'b1 || wr_addr_b !== 32'h0 || wr_data_b !== 32'(want)) begin
      n_err++;
      $display("FAIL single_write: got ready=%b addr=%h data=%0d want 1 00000000 %0d",
               wr_ready_b, wr_addr_b, wr_data_b, want);
    end
    wr_done_b = 1'b1;
    tick();
    wr_done_b = 1'b0;
    n_cmp++;
    if (frame_done_b !== 1'b1 || wr_ready_b !== 1'b0) begin
      n_err++;
      $display("FAIL single_done: got done=%b ready=%b want 1 0", frame_done_b, wr_ready_b);
    end
    tick();
    n_cmp++;
    if (busy_b !== 1'b0) begin
      n_err++;
      $display("FAIL single_busy: got %b want 0", busy_b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if (wr_ready_a !== 1'b0 || busy_a !== 1'b0 || frame_done_a !== 1'b0 || wr_addr_a !== 32'h0) begin
      n_err++;
      $display("FAIL reset_a: got ready=%b busy=%b done=%b addr=%h want 0 0 0 0",
               wr_ready_a, busy_a, frame_done_a, wr_addr_a);
    end
    n_cmp++;
    if (wr_ready_b !== 1'b0 || busy_b !== 1'b0 || frame_done_b !== 1'b0 || wr_addr_b !== 32'h0) begin
      n_err++;
      $display("FAIL reset_b: got ready=%b busy=%b done=%b addr=%h want 0 0 0 0",
               wr_ready_b, busy_b, frame_done_b, wr_addr_b);
    end
  endtask

  task automatic test_basic_frame();
    set_frame_a(0, 0, 0, 0, 0, 5);
    run_frame_a(-1, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_escape_at_start();
    a_b     = 22'd0;
    b_b     = 22'd0;
    xmin_b  = 22'd3072;
    ymin_b  = 22'd0;
    step_b  = 22'd0;
    maxit_b = 8'd20;
    run_single_b(0);
  endtask

  task automatic test_write_stall();
    set_frame_a(0, 0, 0, 0, 0, 5);
    run_frame_a(2, 10, 1'b0, 1'b0, -1);
  endtask

  task automatic test_max_iter_zero();
    set_frame_a(-500, 300, -1024, -512, 256, 0);
    run_frame_a(-1, 0, 1'b0, 1'b1, -1);
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (wr_ready_a !== 1'b0 || busy_a !== 1'b0) begin
        n_err++;
        $display("FAIL ignored_start: cycle %0d got ready=%b busy=%b want 0 0", i, wr_ready_a, busy_a);
      end
    end
  endtask

  task automatic test_abort_restart();
    set_frame_a(0, 0, 0, 0, 0, 5);
    run_frame_a(-1, 0, 1'b0, 1'b0, 3);
    tick();
    run_frame_a(-1, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_random_frames();
    longint av, bv, xm, ym, st;
    int mx;
    for (int k = 0; k < 6; k++) begin
      av = longint'($urandom_range(0, 2400)) - 1200;
      bv = longint'($urandom_range(0, 2400)) - 1200;
      xm = longint'($urandom_range(0, 2048)) - 2048;
      ym = longint'($urandom_range(0, 2048)) - 1536;
      st = longint'($urandom_range(0, 600));
      mx = int'($urandom_range(1, 40));
      set_frame_a(av, bv, xm, ym, st, mx);
      run_frame_a(-1, 0, 1'b1, 1'b0, -1);
    end
  endtask

  task automatic test_back_to_back();
    set_frame_a(-800, 156, -1536, -300, 512, 12);
    run_frame_a(-1, 0, 1'b0, 1'b0, -1);
    set_frame_a(300, -700, 0, 0, 700, 9);
    run_frame_a(-1, 0, 1'b0, 1'b0, -1);
  endtask

`ifdef JULIA_MANDEL_EN
  task automatic test_mandel();
    mandel_b = 1'b1;
    a_b      = 22'd1000;
    b_b      = 22'd1000;
    xmin_b   = 22'd0;
    ymin_b   = 22'd0;
    step_b   = 22'd0;
    maxit_b  = 8'd7;
    run_single_b(7);
    mandel_b = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    start_a = 1'b0; wr_done_a = 1'b0; start_b = 1'b0; wr_done_b = 1'b0;
    a_a = '0; b_a = '0; xmin_a = '0; ymin_a = '0; step_a = '0; maxit_a = '0;
    a_b = '0; b_b = '0; xmin_b = '0; ymin_b = '0; step_b = '0; maxit_b = '0;
`ifdef JULIA_MANDEL_EN
    mandel_a = 1'b0;
    mandel_b = 1'b0;
`endif
    test_reset();
    test_basic_frame();
    test_escape_at_start();
    test_write_stall();
    test_max_iter_zero();
    test_abort_restart();
    test_random_frames();
    test_back_to_back();
`ifdef JULIA_MANDEL_EN
    test_mandel();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
